framebuffer_writer: RTL and testbench
=====================================

// Module: framebuffer_writer
// PURPOSE
//  Write-side engine for the 32x24 8-bpp tile framebuffer that the display read path scans.
//  Accepts draw commands over a valid/ready handshake: set pixel, fill rectangle, clear screen.
//  Emits one framebuffer write per cycle on wr_en/wr_addr/wr_data.
//  Uses the same address map as the read path: addr = y*HPIXELS + x.
// PARAMETERS
//  HPIXELS          32     tiles per row (x range 0..HPIXELS-1)
//  VPIXELS          24     tile rows (y range 0..VPIXELS-1); memory depth = HPIXELS*VPIXELS = 768
//  BLOCKING_FACTOR  20     screen pixels per tile edge; sets active-video limit VPIXELS*BLOCKING_FACTOR = 480
//  CLEAR_COLOR      8'h00  colour written by the reset-time clear and by op CLEAR
// PORTS
//  clk        in   1   system clock
//  rst_n      in   1   asynchronous active-low reset
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   engine can accept; transfer when cmd_valid & cmd_ready
//  cmd_op     in   2   0=PIXEL, 1=RECT, 2=CLEAR, 3=reserved (treated as NOP)
//  cmd_x      in   5   origin column
//  cmd_y      in   5   origin row (values 24..31 are off-screen)
//  cmd_w      in   6   rectangle width, 0..32 (RECT only)
//  cmd_h      in   6   rectangle height, 0..32 (RECT only)
//  cmd_color  in   8   fill colour (PIXEL/RECT)
//  wr_en      out  1   framebuffer write strobe
//  wr_addr    out  10  framebuffer address
//  wr_data    out  8   framebuffer data
//  busy       out  1   high in INIT_CLR or DRAW
//  done       out  1   one-cycle pulse when a command completes
// BEHAVIOUR
//  Reset (async): state=INIT_CLR; wr_en=0, wr_addr=0, wr_data=0, cmd_ready=0, busy=1, done=0.
//  All outputs are registered. Command fields are captured at handshake; inputs are don't-care afterwards.
//  INIT_CLR: starting the first cycle after rst_n rises, writes CLEAR_COLOR to addr 0..767.
//    One write per cycle; 768 cycles total. Then IDLE. done is not pulsed for the init clear.
//  IDLE: cmd_ready=1, busy=0.
//    On handshake, the command resolves to a rectangle and the engine goes to DRAW:
//      PIXEL: x,y,1,1.   CLEAR: 0,0,32,24 with CLEAR_COLOR.
//    cmd_ready drops the cycle after the handshake.
//  Clipping:
//    x_end = min(x+w, HPIXELS); y_end = min(y+h, VPIXELS); sums computed 7 bits wide, no wrap.
//    Empty rectangle (w==0, h==0, or y>=VPIXELS): no writes.
//      Also applies to op 3.
//      done pulses the cycle after the handshake; engine returns to IDLE in that same cycle.
//  DRAW:
//    Scan order is row-major, x innermost.
//    Handshake at cycle N: first wr_en at N+1 with addr y*32+x.
//    Writes continue one per cycle through the last in-range tile.
//    After the last write: done pulses at N+1+count, together with the return to IDLE.
//    cmd_ready=1 from that cycle onward, so back-to-back commands have a 1-cycle gap.
//  Rows wrap at x_end back to the original x, with y+1. The command ends when y reaches y_end.
//  wr_addr never exceeds 767. wr_data is held stable while wr_en=1.
//  Reset mid-operation aborts immediately: outputs go to reset values and INIT_CLR restarts from addr 0.
// CONFIGURATION
//  VBLANK_GATE_EN defined:
//    Adds input port "vc in 10 current vertical scan count" after rst_n.
//    In INIT_CLR and DRAW, a write is issued only when vc >= VPIXELS*BLOCKING_FACTOR (480).
//    Otherwise the scan position holds and wr_en=0.
//    The command resumes exactly where it stalled: no skipped or duplicated tiles.
//    done latency grows by the number of stalled cycles.
//  VBLANK_GATE_EN undefined: no vc port; writes are never stalled.
// TESTING
//  T1 Reset release, no commands:
//    wr_en high for exactly 768 consecutive cycles, addr 0..767, data 8'h00.
//    Then cmd_ready=1, busy=0.
//  T2 PIXEL x=31 y=23 color=8'hff, handshake at N:
//    Single write addr 767, data ff at N+1; done at N+2.
//  T3 RECT x=15 y=0 w=2 h=24 color=ff:
//    48 writes at addrs 15,16,47,48,...,751,752, in order.
//  T4 RECT x=30 y=22 w=10 h=10:
//    Clipped to 4 writes at addrs 734,735,766,767.
//    Separately, RECT y=24 w=5 h=5 -> zero writes; done at N+1.
//  T5 Assert rst_n=0 during a CLEAR at its 100th write:
//    wr_en=0 asynchronously.
//    After release, a full 768-write INIT_CLR from addr 0 and no done pulse.
//  T6 (VBLANK_GATE_EN) RECT 2x1 with vc=100 for 5 cycles, then vc=480:
//    No writes while vc=100.
//    Writes at the next two cycles once vc=480, addrs x,x+1 unchanged.

Source files
------------

// File: rtl/framebuffer_writer.sv
// ---------------------------------------------------------------------------
// framebuffer_writer
//   Write-side engine for the HPIXELS x VPIXELS 8-bpp tile framebuffer that
//   the display read path scans (addr = y*HPIXELS + x). After reset it clears
//   the whole framebuffer to CLEAR_COLOR, then accepts draw commands (PIXEL,
//   RECT, CLEAR) over a valid/ready handshake. Each command is resolved to a
//   clipped rectangle and written row-major, one tile per cycle.
//
// Ports
//   clk, rst_n         system clock, asynchronous active-low reset
//   vc                 current vertical scan count (VBLANK_GATE_EN only)
//   cmd_valid/ready    command handshake
//   cmd_op             0=PIXEL 1=RECT 2=CLEAR 3=NOP
//   cmd_x/y/w/h/color  rectangle origin, size and colour
//   wr_en/addr/data    framebuffer write port (one write per cycle)
//   busy               high while clearing or drawing
//   done               one-cycle pulse when a command completes
//
// Configuration
//   VBLANK_GATE_EN     when defined, adds the vc input and stalls writes
//                      until vc >= VPIXELS*BLOCKING_FACTOR (vertical blank).
// ---------------------------------------------------------------------------
module framebuffer_writer #(
  parameter int unsigned HPIXELS         = 32,
  parameter int unsigned VPIXELS         = 24,
  parameter int unsigned BLOCKING_FACTOR = 20,
  parameter logic [7:0]  CLEAR_COLOR     = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef VBLANK_GATE_EN
  input  logic [9:0] vc,
`endif
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [4:0] cmd_x,
  input  logic [4:0] cmd_y,
  input  logic [5:0] cmd_w,
  input  logic [5:0] cmd_h,
  input  logic [7:0] cmd_color,
  output logic       wr_en,
  output logic [9:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       done
);

  localparam logic [5:0] HP6         = 6'(HPIXELS);
  localparam logic [5:0] VP6         = 6'(VPIXELS);
  localparam logic [6:0] HP7         = 7'(HPIXELS);
  localparam logic [6:0] VP7         = 7'(VPIXELS);
  localparam logic [9:0] HP10        = 10'(HPIXELS);
  localparam logic [9:0] VBLANK_LINE = 10'(VPIXELS * BLOCKING_FACTOR);

  typedef enum logic [1:0] {
    S_INIT_CLR = 2'd0,
    S_IDLE     = 2'd1,
    S_DRAW     = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] x_q, x_d;        // next tile column to write
  logic [4:0] y_q, y_d;        // next tile row to write; == yend_q when finished
  logic [4:0] x0_q, x0_d;      // row restart column
  logic [5:0] xend_q, xend_d;  // clipped exclusive column limit
  logic [5:0] yend_q, yend_d;  // clipped exclusive row limit
  logic [7:0] color_q, color_d;
  logic       wr_en_q, wr_en_d;
  logic [9:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  logic gate;
`ifdef VBLANK_GATE_EN
  assign gate = (vc >= VBLANK_LINE);
`else
  assign gate = 1'b1;
`endif

  // Command resolution and clipping
  logic [4:0] r_x, r_y;
  logic [5:0] r_w, r_h;
  logic [7:0] r_color;
  logic [6:0] r_xsum, r_ysum;
  logic [5:0] r_xend, r_yend;
  logic       r_empty;

  always_comb begin
    r_x     = cmd_x;
    r_y     = cmd_y;
    r_w     = cmd_w;
    r_h     = cmd_h;
    r_color = cmd_color;
    case (cmd_op)
      2'd0: begin
        r_w = 6'd1;
        r_h = 6'd1;
      end
      2'd1: ;
      2'd2: begin
        r_x     = '0;
        r_y     = '0;
        r_w     = HP6;
        r_h     = VP6;
        r_color = CLEAR_COLOR;
      end
      default: begin
        r_w = '0;
        r_h = '0;
      end
    endcase
    r_xsum  = {2'b00, r_x} + {1'b0, r_w};
    r_ysum  = {2'b00, r_y} + {1'b0, r_h};
    r_xend  = (r_xsum > HP7) ? HP6 : r_xsum[5:0];
    r_yend  = (r_ysum > VP7) ? VP6 : r_ysum[5:0];
    r_empty = (r_w == '0) || (r_h == '0) || ({1'b0, r_y} >= VP6);
  end

  // Position being written this cycle: the freshly resolved origin on a
  // handshake (so the first write lands the cycle after it), otherwise the
  // stored scan position.
  logic       accept;
  logic [4:0] cur_x, cur_y, cur_x0;
  logic [5:0] cur_xend;
  logic [5:0] nx;

  assign accept = (state_q == S_IDLE) && cmd_valid && cmd_ready_q;

  always_comb begin
    cur_x    = x_q;
    cur_y    = y_q;
    cur_x0   = x0_q;
    cur_xend = xend_q;
    if (state_q == S_IDLE) begin
      cur_x    = r_x;
      cur_y    = r_y;
      cur_x0   = r_x;
      cur_xend = r_xend;
    end
    nx = {1'b0, cur_x} + 6'd1;
  end

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    x0_d        = x0_q;
    xend_d      = xend_q;
    yend_d      = yend_q;
    color_d     = color_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (r_empty) begin
            done_d = 1'b1;
          end else begin
            state_d     = S_DRAW;
            cmd_ready_d = 1'b0;
            busy_d      = 1'b1;
            x_d         = r_x;
            y_d         = r_y;
            x0_d        = r_x;
            xend_d      = r_xend;
            yend_d      = r_yend;
            color_d     = r_color;
          end
        end
      end
      S_INIT_CLR, S_DRAW: begin
        if ({1'b0, y_q} == yend_q) begin
          state_d     = S_IDLE;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
          done_d      = (state_q == S_DRAW);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Shared write/advance path for handshake, init clear and draw
    if (gate && ((accept && !r_empty) ||
                 (((state_q == S_INIT_CLR) || (state_q == S_DRAW)) &&
                  ({1'b0, y_q} != yend_q)))) begin
      wr_en_d   = 1'b1;
      wr_addr_d = 10'(cur_y) * HP10 + 10'(cur_x);
      wr_data_d = accept ? r_color : color_q;
      if (nx >= cur_xend) begin
        x_d = cur_x0;
        y_d = cur_y + 5'd1;
      end else begin
        x_d = nx[4:0];
        y_d = cur_y;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT_CLR;
      x_q         <= '0;
      y_q         <= '0;
      x0_q        <= '0;
      xend_q      <= HP6;
      yend_q      <= VP6;
      color_q     <= CLEAR_COLOR;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      x0_q        <= x0_d;
      xend_q      <= xend_d;
      yend_q      <= yend_d;
      color_q     <= color_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// ---------------------------------------------------------------------------
// tb_framebuffer_writer
//   Scoreboard bench for framebuffer_writer: expected writes are queued when a
//   command is driven and compared as the DUT emits them.
// ---------------------------------------------------------------------------
module tb_framebuffer_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_x, cmd_y;
  logic [5:0] cmd_w, cmd_h;
  logic [7:0] cmd_color;
  logic       wr_en;
  logic [9:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy, done;
`ifdef VBLANK_GATE_EN
  logic [9:0] vc;
`endif

  always #5 clk = ~clk;

  framebuffer_writer #(
    .HPIXELS(32), .VPIXELS(24), .BLOCKING_FACTOR(20), .CLEAR_COLOR(8'h00)
  ) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef VBLANK_GATE_EN
    .vc(vc),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .cmd_color(cmd_color), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  typedef struct {
    logic [9:0] a;
    logic [7:0] d;
  } wr_t;
  wr_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: clipped rectangle, row-major, x innermost
  function automatic int push_rect(input int x, input int y, input int w, input int h,
                                   input logic [7:0] c);
    int xe, ye, n;
    wr_t e;
    xe = (x + w > 32) ? 32 : x + w;
    ye = (y + h > 24) ? 24 : y + h;
    n  = 0;
    for (int yy = y; yy < ye; yy++)
      for (int xx = x; xx < xe; xx++) begin
        e.a = 10'(yy * 32 + xx);
        e.d = c;
        exp_q.push_back(e);
        n++;
      end
    return n;
  endfunction

  function automatic int model_cmd(input logic [1:0] op, input int x, input int y,
                                   input int w, input int h, input logic [7:0] c);
    case (op)
      2'd0:    return push_rect(x, y, 1, 1, c);
      2'd1:    return push_rect(x, y, w, h, c);
      2'd2:    return push_rect(0, 0, 32, 24, 8'h00);
      default: return 0;
    endcase
  endfunction

  // Write monitor
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        chk("sb_underflow", exp_q.size(), 1);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", {22'b0, wr_addr}, {22'b0, e.a});
        chk("wr_data", {24'b0, wr_data}, {24'b0, e.d});
      end
    end
  end

  task automatic drive_cmd(input logic [1:0] op, input int x, input int y,
                           input int w, input int h, input logic [7:0] c);
    int k;
    k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_op    = op;
    cmd_x     = 5'(x);
    cmd_y     = 5'(y);
    cmd_w     = 6'(w);
    cmd_h     = 6'(h);
    cmd_color = c;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    // Fields are don't-care after the handshake
    cmd_op    = 2'($urandom);
    cmd_x     = 5'($urandom);
    cmd_y     = 5'($urandom);
    cmd_w     = 6'($urandom);
    cmd_h     = 6'($urandom);
    cmd_color = 8'($urandom);
  endtask

  task automatic send_cmd(input string tag, input logic [1:0] op, input int x, input int y,
                          input int w, input int h, input logic [7:0] c);
    int n, k;
    n = model_cmd(op, x, y, w, h, c);
    drive_cmd(op, x, y, w, h, c);
    if (n > 0) chk({tag, "_ready_drop"}, cmd_ready, 0);
    k = 1;
    while (!done && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_lat"}, k, n + 1);
    chk({tag, "_idle_ready"}, cmd_ready, 1);
    chk({tag, "_idle_busy"}, busy, 0);
    @(negedge clk);
    chk({tag, "_done_width"}, done, 0);
  endtask

  // Called at the negedge where rst_n is released
  task automatic wait_init(input string tag);
    int k, run, dn;
    k = 0;
    run = 0;
    dn = 0;
    @(negedge clk);
    while (!wr_en && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_start_lat"}, k, 0);
    while (wr_en && run < 2000) begin
      run++;
      if (done) dn++;
      @(negedge clk);
    end
    chk({tag, "_len"}, run, 768);
    chk({tag, "_no_done"}, dn, 0);
    chk({tag, "_ready"}, cmd_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done_end"}, done, 0);
  endtask

  initial begin
    int k, n;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_x     = '0;
    cmd_y     = '0;
    cmd_w     = '0;
    cmd_h     = '0;
    cmd_color = '0;
`ifdef VBLANK_GATE_EN
    vc        = 10'd600;
`endif
    repeat (3) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", {22'b0, wr_addr}, 0);
    chk("rst_wr_data", {24'b0, wr_data}, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_done", done, 0);

    // T1: init clear
    n = push_rect(0, 0, 32, 24, 8'h00);
    rst_n = 1'b1;
    wait_init("t1_init");

    // T2..T4 and other shapes
    send_cmd("t2_pixel", 2'd0, 31, 23, 0, 0, 8'hff);
    send_cmd("t3_rect", 2'd1, 15, 0, 2, 24, 8'hff);
    send_cmd("t4_clip", 2'd1, 30, 22, 10, 10, 8'h5a);
    send_cmd("t4_offscr", 2'd1, 3, 24, 5, 5, 8'h11);
    send_cmd("nop", 2'd3, 4, 4, 3, 3, 8'h22);
    send_cmd("w0", 2'd1, 4, 4, 0, 3, 8'h33);
    send_cmd("h0", 2'd1, 4, 4, 3, 0, 8'h44);
    send_cmd("pix_off", 2'd0, 0, 31, 0, 0, 8'h55);
    send_cmd("full_w", 2'd1, 0, 5, 32, 2, 8'h66);
    for (int i = 0; i < 6; i++)
      send_cmd("rand_rect", 2'd1, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 32)), int'($urandom_range(0, 32)), 8'($urandom));
    send_cmd("clear", 2'd2, 7, 7, 1, 1, 8'hee);

    // T5: reset during CLEAR at its 100th write
    n = model_cmd(2'd2, 0, 0, 0, 0, 8'h00);
    drive_cmd(2'd2, 0, 0, 0, 0, 8'h00);
    k = 0;
    while (!(wr_en && wr_addr == 10'd99) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("t5_hit99", {22'b0, wr_addr}, 99);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_wr_en", wr_en, 0);
    chk("t5_async_busy", busy, 1);
    chk("t5_async_ready", cmd_ready, 0);
    exp_q.delete();
    n = push_rect(0, 0, 32, 24, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("t5_init");

`ifdef VBLANK_GATE_EN
    // T6: writes stall until vertical blank
    vc = 10'd100;
    n = push_rect(5, 3, 2, 1, 8'h3c);
    drive_cmd(2'd1, 5, 3, 2, 1, 8'h3c);
    for (int i = 0; i < 5; i++) begin
      chk("t6_stall", wr_en, 0);
      if (i < 4) @(negedge clk);
    end
    vc = 10'd480;
    @(negedge clk);
    chk("t6_wr0", wr_en, 1);
    @(negedge clk);
    chk("t6_wr1", wr_en, 1);
    @(negedge clk);
    chk("t6_done", done, 1);
    @(negedge clk);
`endif

    chk("sb_left", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
